// File: rtl/traffic_light_monitor_if.sv
// ============================================================================
// Module      : traffic_light_monitor_if
// Description : Intersection light bus seen by the light monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface traffic_light_monitor_if;
  logic [2:0]  north_dir;
  logic [2:0]  south_dir;
  logic [2:0]  east_dir;
  logic [2:0]  west_dir;
  logic        err_clear;
  logic [5:0]  err_flags;
  logic        err_pulse;
  logic [1:0]  active_dir;
  logic        rotation_done;
  logic [15:0] phase_cnt;

  modport master (
    output north_dir, south_dir, east_dir, west_dir, err_clear,
    input  err_flags, err_pulse, active_dir, rotation_done, phase_cnt
  );

  modport slave (
    input  north_dir, south_dir, east_dir, west_dir, err_clear,
    output err_flags, err_pulse, active_dir, rotation_done, phase_cnt
  );
endinterface

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module      : traffic_light_monitor
// Description : Passive checker of light codes, phase order and phase timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
  parameter int GREEN_MIN  = 15,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_MAX = 3,
  parameter int ALLRED_MAX = 2
) (
  input  wire logic               clk,
  input  wire logic               reset,
  traffic_light_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  localparam logic [2:0]  C_RED    = 3'b001;
  localparam logic [2:0]  C_YEL    = 3'b010;
  localparam logic [2:0]  C_GRN    = 3'b100;
  localparam logic [15:0] C_GMIN   = 16'(GREEN_MIN);
  localparam logic [15:0] C_GMAX   = 16'(GREEN_MAX);
  localparam logic [15:0] C_YMAX   = 16'(YELLOW_MAX);
  localparam logic [15:0] C_ARMAX  = 16'(ALLRED_MAX);

  state_t      state_q, state_d;
  logic [1:0]  active_q, active_d;
  logic [15:0] phase_cnt_q, phase_cnt_d;
  logic [5:0]  err_flags_q;
  logic        err_pulse_q;
  logic        rot_done_q, rot_done_d;
  logic [2:0]  rot_cnt_q, rot_cnt_d;

  logic [2:0]  w_code [4];
  logic [3:0]  w_grn, w_yel, w_bad, w_act_mask;
  logic [1:0]  w_grn_idx;
  logic        w_act_grn, w_act_yel, w_act_red;
  logic        w_other_grn, w_other_yel, w_in_phase, w_hold, w_enter, w_rot_cand;
  logic        e_illegal, e_conflict, e_seq, e_order, e_timing, e_stall;
  logic [5:0]  w_err_new;

  assign w_code[0] = bus.north_dir;
  assign w_code[1] = bus.south_dir;
  assign w_code[2] = bus.east_dir;
  assign w_code[3] = bus.west_dir;

  for (genvar i = 0; i < 4; i++) begin : g_dir
    assign w_grn[i] = (w_code[i] == C_GRN);
    assign w_yel[i] = (w_code[i] == C_YEL);
    assign w_bad[i] = !(w_code[i] == C_RED || w_code[i] == C_YEL || w_code[i] == C_GRN);
  end

  always_comb begin
    w_grn_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_grn[i]) w_grn_idx = 2'(i);
    end
  end

  assign w_act_mask  = 4'b0001 << active_q;
  assign w_act_grn   = w_grn[active_q];
  assign w_act_yel   = w_yel[active_q];
  assign w_act_red   = (w_code[active_q] == C_RED);
  assign w_other_grn = |(w_grn & ~w_act_mask);
  assign w_other_yel = |(w_yel & ~w_act_mask);
  assign w_in_phase  = (state_q == S_GREEN) || (state_q == S_YELLOW);

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    w_enter    = 1'b0;
    w_rot_cand = 1'b0;
    e_illegal  = |w_bad;
    e_conflict = ($countones(w_grn | w_yel) > 1) || (w_in_phase && w_other_grn);
    e_seq      = (w_in_phase && w_other_grn) || ((state_q != S_WAIT) && w_other_yel);
    e_order    = 1'b0;
    e_timing   = 1'b0;
    e_stall    = 1'b0;
    // Malformed or conflicting cycles never move the FSM; counters keep running.
    w_hold     = e_illegal || e_conflict;

    case (state_q)
      S_WAIT: begin
        if (!w_hold && |w_grn) begin
          state_d  = S_GREEN;
          active_d = w_grn_idx;
          w_enter  = 1'b1;
        end
      end
      S_GREEN: begin
        if (w_act_yel) begin
          if (!w_hold) begin
            state_d  = S_YELLOW;
            w_enter  = 1'b1;
            e_timing = (phase_cnt_q < C_GMIN);
          end
        end else if (w_act_red) begin
          if (!w_hold) begin
            e_seq   = 1'b1;
            state_d = S_ALLRED;
            w_enter = 1'b1;
          end
        end else if (w_act_grn && phase_cnt_q == C_GMAX) begin
          e_timing = 1'b1;
        end
      end
      S_YELLOW: begin
        if (w_act_red) begin
          if (!w_hold) begin
            state_d    = S_ALLRED;
            w_enter    = 1'b1;
            w_rot_cand = (active_q == 2'd3) && (rot_cnt_q == 3'd4);
          end
        end else if (w_act_grn) begin
          e_seq = 1'b1;
        end else if (w_act_yel && phase_cnt_q == C_YMAX) begin
          e_timing = 1'b1;
        end
      end
      default: begin
        if (!w_hold && |w_grn) begin
          state_d  = S_GREEN;
          active_d = w_grn_idx;
          w_enter  = 1'b1;
          e_order  = (w_grn_idx != 2'(active_q + 2'd1));
        end else if (!(|w_grn) && phase_cnt_q == C_ARMAX) begin
          e_stall = 1'b1;
        end
      end
    endcase
  end

  assign w_err_new = {e_stall, e_timing, e_order, e_seq, e_conflict, e_illegal};

  // rot_cnt_q counts clean in-order greens since the last north green (4 = N,S,E,W).
  always_comb begin
    rot_cnt_d  = rot_cnt_q;
    rot_done_d = 1'b0;
    if (|w_err_new) begin
      rot_cnt_d = 3'd0;
    end else if (w_rot_cand) begin
      rot_done_d = 1'b1;
      rot_cnt_d  = 3'd0;
    end else if (w_enter && state_d == S_GREEN) begin
      if (active_d == 2'd0)
        rot_cnt_d = 3'd1;
      else if (rot_cnt_q != 3'd0 && {1'b0, active_d} == rot_cnt_q)
        rot_cnt_d = rot_cnt_q + 3'd1;
      else
        rot_cnt_d = 3'd0;
    end
  end

  assign phase_cnt_d = w_enter ? 16'd1
                     : (phase_cnt_q == 16'hFFFF) ? phase_cnt_q
                     : phase_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_WAIT;
      active_q    <= 2'd0;
      phase_cnt_q <= 16'd0;
      err_flags_q <= 6'd0;
      err_pulse_q <= 1'b0;
      rot_done_q  <= 1'b0;
      rot_cnt_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      phase_cnt_q <= phase_cnt_d;
      err_flags_q <= (bus.err_clear ? 6'd0 : err_flags_q) | w_err_new;
      err_pulse_q <= |w_err_new;
      rot_done_q  <= rot_done_d;
      rot_cnt_q   <= rot_cnt_d;
    end
  end

  assign bus.err_flags     = err_flags_q;
  assign bus.err_pulse     = err_pulse_q;
  assign bus.active_dir    = active_q;
  assign bus.rotation_done = rot_done_q;
  assign bus.phase_cnt     = phase_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Scoreboard bench for traffic_light_monitor, directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_monitor;

  localparam logic [2:0]  R     = 3'b001;
  localparam logic [2:0]  Y     = 3'b010;
  localparam logic [2:0]  G     = 3'b100;
  localparam logic [11:0] ALL_R = {R, R, R, R};

  typedef struct {
    int         cyc;
    logic [5:0] fl;
    logic       p;
    logic [1:0] a;
    logic       r;
    int         c;
    string      nm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   edge_n = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   done = 1'b0;
  exp_t q[$];

  traffic_light_monitor_if bus ();

  traffic_light_monitor #(
    .GREEN_MIN (15),
    .GREEN_MAX (16),
    .YELLOW_MAX(3),
    .ALLRED_MAX(2)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [11:0] only(input int d, input logic [2:0] c);
    logic [11:0] v;
    v = ALL_R;
    v[(3 - d) * 3 +: 3] = c;
    return v;
  endfunction

  task automatic push(input logic [5:0] fl, input logic p, input logic [1:0] a,
                      input logic r, input int c, input string nm);
    exp_t e;
    e.cyc = edge_n; e.fl = fl; e.p = p; e.a = a; e.r = r; e.c = c; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [11:0] d, input logic [5:0] fl, input logic p,
                     input logic [1:0] a, input logic r, input int c, input string nm);
    {bus.north_dir, bus.south_dir, bus.east_dir, bus.west_dir} = d;
    @(posedge clk);
    #1;
    push(fl, p, a, r, c, nm);
  endtask

  task automatic run(input int n, input logic [11:0] d, input logic [5:0] fl,
                     input logic [1:0] a, input int c0, input string nm);
    for (int i = 0; i < n; i++) cyc(d, fl, 1'b0, a, 1'b0, c0 + i, nm);
  endtask

  // Green from count gs for gl cycles, yellow 2, all-red 1.
  task automatic do_phase(input int d, input int gs, input int gl,
                          input logic [5:0] fl, input logic rot);
    run(gl, only(d, G), fl, 2'(d), gs, "green");
    run(2, only(d, Y), fl, 2'(d), 1, "yellow");
    cyc(ALL_R, fl, 1'b0, 2'(d), rot, 1, "allred");
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= edge_n) begin
      e = q.pop_front();
      n_tests++;
      if (bus.err_flags !== e.fl || bus.err_pulse !== e.p || bus.active_dir !== e.a ||
          bus.rotation_done !== e.r || (e.c >= 0 && bus.phase_cnt !== 16'(e.c))) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got flags=%b pulse=%b act=%0d rot=%b cnt=%0d, want flags=%b pulse=%b act=%0d rot=%b cnt=%0d",
                 e.nm, e.cyc, bus.err_flags, bus.err_pulse, bus.active_dir,
                 bus.rotation_done, bus.phase_cnt, e.fl, e.p, e.a, e.r, e.c);
      end
    end
    if (done) begin
      n_tests++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, want summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.err_clear = 1'b0;
    cyc(ALL_R, 6'h00, 1'b0, 2'd0, 1'b0, 0, "reset");
    cyc(ALL_R, 6'h00, 1'b0, 2'd0, 1'b0, 0, "reset");
    rst_n = 1'b1;
    cyc(ALL_R, 6'h00, 1'b0, 2'd0, 1'b0, 1, "wait_red");

    // Two clean N,S,E,W loops
    for (int l = 0; l < 2; l++)
      for (int d = 0; d < 4; d++)
        do_phase(d, 1, 15, 6'h00, d == 3);

    // Short north green, then over-long south green
    run(10, only(0, G), 6'h00, 2'd0, 1, "short_green");
    cyc(only(0, Y), 6'h10, 1'b1, 2'd0, 1'b0, 1, "short_green_flag");
    cyc(only(0, Y), 6'h10, 1'b0, 2'd0, 1'b0, 2, "yellow");
    cyc(ALL_R, 6'h10, 1'b0, 2'd0, 1'b0, 1, "allred");
    run(16, only(1, G), 6'h10, 2'd1, 1, "long_green");
    cyc(only(1, G), 6'h10, 1'b1, 2'd1, 1'b0, 17, "long_green_flag");
    run(2, only(1, Y), 6'h10, 2'd1, 1, "yellow");
    cyc(ALL_R, 6'h10, 1'b0, 2'd1, 1'b0, 1, "allred");

    // Clear, then north+east green conflict during east phase
    bus.err_clear = 1'b1;
    cyc(only(2, G), 6'h00, 1'b0, 2'd2, 1'b0, 1, "clear_east");
    bus.err_clear = 1'b0;
    run(4, only(2, G), 6'h00, 2'd2, 2, "green");
    cyc({G, R, G, R}, 6'h06, 1'b1, 2'd2, 1'b0, 6, "conflict");
    do_phase(2, 7, 9, 6'h06, 1'b0);
    bus.err_clear = 1'b1;
    cyc(only(3, G), 6'h00, 1'b0, 2'd3, 1'b0, 1, "clear_west");
    bus.err_clear = 1'b0;
    do_phase(3, 2, 14, 6'h00, 1'b0);

    // North then east (south skipped): no rotation_done this loop
    do_phase(0, 1, 15, 6'h00, 1'b0);
    cyc(only(2, G), 6'h08, 1'b1, 2'd2, 1'b0, 1, "bad_order");
    do_phase(2, 2, 14, 6'h08, 1'b0);
    do_phase(3, 1, 15, 6'h08, 1'b0);

    // Illegal code with simultaneous clear, then all-red stall
    bus.err_clear = 1'b1;
    cyc({R, 3'b011, R, R}, 6'h01, 1'b1, 2'd3, 1'b0, 2, "illegal_clear");
    bus.err_clear = 1'b0;
    cyc(ALL_R, 6'h21, 1'b1, 2'd3, 1'b0, 3, "stall");
    cyc(ALL_R, 6'h21, 1'b0, 2'd3, 1'b0, 4, "stall_once");
    run(5, only(0, G), 6'h21, 2'd0, 1, "green");

    // Asynchronous reset mid-green with flags set
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push(6'h00, 1'b0, 2'd0, 1'b0, 0, "async_reset");
    cyc(ALL_R, 6'h00, 1'b0, 2'd0, 1'b0, 0, "in_reset");
    rst_n = 1'b1;
    run(4, only(1, G), 6'h00, 2'd1, 1, "first_green_south");

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

endmodule

`default_nettype wire
